ram_arbiter: RTL and testbench

- Sequences and shares the single-port 16x8 program/data RAM between two requesters.
  - Port A is the CPU control path.
  - Port B is the program loader or front-panel path.
- Converts level req/ack transactions into correctly timed `ram_we`/`ram_oe`/`ram_addr`/`ram_wdata` sequences.
- Captures read data back from the RAM.
- Sits between the requesters and the RAM; it is the only driver of the RAM control pins.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arb_select.sv | 29 ++
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM arbiter
package ram_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/ram_arb_select.sv
// rtl/ram_arb_select.sv - combinational one-hot grant, grant[0]=A, grant[1]=B
// RAM_ARB_ROUND_ROBIN_EN: ties go to the port not served last
module ram_arb_select
  import ram_arb_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic       last_port,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (a_req && b_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      grant = (last_port == PORT_A) ? 2'b10 : 2'b01;
`else
      grant = 2'b01;
`endif
    end else if (a_req) begin
      grant = 2'b01;
    end else if (b_req) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port req/ack sequencer for a single-port registered RAM
// RAM_ARB_ROUND_ROBIN_EN: alternating tie-break instead of fixed A-over-B priority
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  state_t                state, state_next;
  logic                  owner, owner_next;
  logic                  lat_we, lat_we_next;
  logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_next;
  logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_next;
  logic [1:0]            grant;

  logic                  ram_we_d, ram_oe_d, a_ack_d, b_ack_d, busy_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_port;

  ram_arb_select u_select (
    .a_req     (a_req),
    .b_req     (b_req),
    .last_port (last_port),
    .grant     (grant)
  );

  // Reset to B so that the very first tie goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_port <= PORT_B;
    end else if (state_next == DONE) begin
      last_port <= owner_next;
    end
  end
`else
  ram_arb_select u_select (
    .a_req (a_req),
    .b_req (b_req),
    .grant (grant)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= PORT_A;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      lat_we    <= lat_we_next;
      lat_addr  <= lat_addr_next;
      lat_wdata <= lat_wdata_next;
    end
  end

  // Requester inputs only matter in IDLE; the latch freezes them for the transaction.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    lat_we_next    = lat_we;
    lat_addr_next  = lat_addr;
    lat_wdata_next = lat_wdata;
    case (state)
      IDLE: begin
        if (grant[1]) begin
          owner_next     = PORT_B;
          lat_we_next    = b_we;
          lat_addr_next  = b_addr;
          lat_wdata_next = b_wdata;
          state_next     = b_we ? WR : RD1;
        end else if (grant[0]) begin
          owner_next     = PORT_A;
          lat_we_next    = a_we;
          lat_addr_next  = a_addr;
          lat_wdata_next = a_wdata;
          state_next     = a_we ? WR : RD1;
        end
      end
      WR:      state_next = DONE;
      RD1:     state_next = RD2;
      RD2:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without a cycle of lag.
  always_comb begin
    ram_we_d    = (state_next == WR);
    ram_oe_d    = (state_next == RD1) || (state_next == RD2);
    ram_addr_d  = (ram_we_d || ram_oe_d) ? lat_addr_next : '0;
    ram_wdata_d = ram_we_d ? lat_wdata_next : '0;
    a_ack_d     = (state_next == DONE) && (owner_next == PORT_A);
    b_ack_d     = (state_next == DONE) && (owner_next == PORT_B);
    busy_d      = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      busy      <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      ram_we    <= ram_we_d;
      ram_oe    <= ram_oe_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      a_ack     <= a_ack_d;
      b_ack     <= b_ack_d;
      busy      <= busy_d;
      if (state == RD2) begin
        if (owner == PORT_A) begin
          a_rdata <= ram_rdata;
        end else begin
          b_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed checks of ram_arbiter against a transaction model
module tb_ram_arbiter;

  logic       clk, rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic       a_ack, b_ack, ram_we, ram_oe, busy;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered single-port RAM seen by the DUT.
  logic [7:0] mem [16];
  initial ram_rdata = 8'h00;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_oe) ram_rdata <= mem[ram_addr];
  end

  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: offsets from the sampling edge decide what each output must be.
  int         cyc, m_start, m_len;
  bit         m_act, m_port, m_we, m_last;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, m_rval;
  logic [7:0] shadow [16];
  logic       e_we, e_oe, e_aack, e_back, e_busy;
  logic [3:0] e_addr;
  logic [7:0] e_wdata, e_ardata, e_brdata;

  task automatic model_reset();
    m_act = 0; m_last = 1; cyc = 0; m_start = 0; m_len = 0;
    e_we = 0; e_oe = 0; e_aack = 0; e_back = 0; e_busy = 0;
    e_addr = 4'h0; e_wdata = 8'h00; e_ardata = 8'h00; e_brdata = 8'h00;
  endtask

  task automatic model_edge();
    int o;
    cyc++;
    if (m_act && (cyc - m_start) >= m_len) m_act = 0;
    if (!m_act && (a_req || b_req)) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      m_port = (a_req && b_req) ? !m_last : b_req && !a_req;
`else
      m_port = !a_req;
`endif
      m_we    = m_port ? b_we : a_we;
      m_addr  = m_port ? b_addr : a_addr;
      m_wdata = m_port ? b_wdata : a_wdata;
      m_start = cyc;
      m_len   = m_we ? 3 : 4;
      if (m_we) shadow[m_addr] = m_wdata;
      else m_rval = shadow[m_addr];
      m_last = m_port;
      m_act  = 1;
    end
    e_we = 0; e_oe = 0; e_aack = 0; e_back = 0; e_busy = 0;
    e_addr = 4'h0; e_wdata = 8'h00;
    if (m_act) begin
      o = cyc - m_start;
      if (o <= m_len - 2) e_busy = 1;
      if (m_we && o == 0) begin e_we = 1; e_addr = m_addr; e_wdata = m_wdata; end
      if (!m_we && o <= 1) begin e_oe = 1; e_addr = m_addr; end
      if (o == m_len - 2) begin
        if (m_port) e_back = 1; else e_aack = 1;
        if (!m_we) begin
          if (m_port) e_brdata = m_rval; else e_ardata = m_rval;
        end
      end
    end
  endtask

  int         we_cnt = 0;
  int         a_ack_cnt = 0;
  logic [3:0] we_addr_last;
  logic [7:0] we_data_last;
  bit         ack_q [$];

  initial forever begin
    @(negedge clk);
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_oe", 32'(ram_oe), 32'(e_oe));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    chk("a_ack", 32'(a_ack), 32'(e_aack));
    chk("b_ack", 32'(b_ack), 32'(e_back));
    chk("a_rdata", 32'(a_rdata), 32'(e_ardata));
    chk("b_rdata", 32'(b_rdata), 32'(e_brdata));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("we_oe_excl", 32'(ram_we && ram_oe), 32'h0);
    if (ram_we) begin we_cnt++; we_addr_last = ram_addr; we_data_last = ram_wdata; end
    if (a_ack) begin a_ack_cnt++; ack_q.push_back(1'b0); end
    if (b_ack) ack_q.push_back(1'b1);
  end

  bit a_hold, b_hold, rand_mode, a_ack_s, b_ack_s;

  task automatic issue(input bit port, input bit we, input logic [3:0] addr, input logic [7:0] data);
    if (!port) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    else       begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
  endtask

  // One clock: sample acks, let the model see the edge, then drive the requesters.
  task automatic step();
    @(negedge clk);
    a_ack_s = a_ack;
    b_ack_s = b_ack;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if (a_ack_s && !a_hold) a_req = 0;
    else if (rand_mode && !a_req && $urandom_range(0, 2) == 0)
      issue(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    if (b_ack_s && !b_hold) b_req = 0;
    else if (rand_mode && !b_req && $urandom_range(0, 2) == 0)
      issue(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
  endtask

  task automatic wait_ack(input bit port, output int lat);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (port ? b_ack_s : a_ack_s) begin lat = n; break; end
    end
    if (lat < 0) chk("ack_timeout", 32'h0, 32'h1);
  endtask

  int lat, we0, ac0;

  initial begin
    rst_n = 0; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 4'h0; b_addr = 4'h0; a_wdata = 8'h00; b_wdata = 8'h00;
    a_hold = 0; b_hold = 0; rand_mode = 0; a_ack_s = 0; b_ack_s = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      shadow[i] = mem[i];
    end
    model_reset();
    step(); step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_a_rdata", 32'(a_rdata), 32'h0);
    chk("rst_ram_oe", 32'(ram_oe), 32'h0);
    rst_n = 1;
    step();

    // A writes AB to 3, then reads it back
    we0 = we_cnt;
    issue(1'b0, 1'b1, 4'h3, 8'hAB);
    wait_ack(1'b0, lat);
    chk("a_wr_latency", 32'(lat), 32'd2);
    chk("a_wr_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("a_wr_addr", 32'(we_addr_last), 32'h3);
    chk("a_wr_data", 32'(we_data_last), 32'hAB);
    issue(1'b0, 1'b0, 4'h3, 8'h00);
    wait_ack(1'b0, lat);
    chk("a_rd_latency", 32'(lat), 32'd3);
    chk("a_rd_data", 32'(a_rdata), 32'hAB);

    // B writes CD to A, then reads it back; A untouched
    ac0 = a_ack_cnt;
    issue(1'b1, 1'b1, 4'hA, 8'hCD);
    wait_ack(1'b1, lat);
    chk("b_wr_latency", 32'(lat), 32'd2);
    issue(1'b1, 1'b0, 4'hA, 8'h00);
    wait_ack(1'b1, lat);
    chk("b_rd_latency", 32'(lat), 32'd3);
    chk("b_rd_data", 32'(b_rdata), 32'hCD);
    chk("b_only_no_a_ack", 32'(a_ack_cnt - ac0), 32'd0);
    chk("b_only_a_rdata", 32'(a_rdata), 32'hAB);

    // simultaneous reads: A first, then B
    we0 = we_cnt;
    ack_q.delete();
    issue(1'b0, 1'b0, 4'h3, 8'h00);
    issue(1'b1, 1'b0, 4'hA, 8'h00);
    wait_ack(1'b0, lat);
    chk("tie_a_latency", 32'(lat), 32'd3);
    wait_ack(1'b1, lat);
    chk("tie_b_latency", 32'(lat), 32'd3);
    chk("tie_ack_count", 32'(ack_q.size()), 32'd2);
    chk("tie_first_a", 32'(ack_q[0]), 32'h0);
    chk("tie_second_b", 32'(ack_q[1]), 32'h1);
    chk("tie_a_rdata", 32'(a_rdata), 32'hAB);
    chk("tie_b_rdata", 32'(b_rdata), 32'hCD);
    chk("tie_no_write", 32'(we_cnt - we0), 32'd0);

    // reset in the middle of a read
    ac0 = a_ack_cnt;
    issue(1'b0, 1'b0, 4'h3, 8'h00);
    step(); step();
    #2;
    rst_n = 0;
    model_reset();
    a_req = 0;
    #1;
    chk("midrst_ram_oe", 32'(ram_oe), 32'h0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_a_rdata", 32'(a_rdata), 32'h0);
    chk("midrst_b_rdata", 32'(b_rdata), 32'h0);
    step(); step();
    rst_n = 1;
    step();
    chk("midrst_no_ack", 32'(a_ack_cnt - ac0), 32'd0);
    issue(1'b0, 1'b0, 4'h3, 8'h00);
    wait_ack(1'b0, lat);
    chk("post_rst_ram_kept", 32'(a_rdata), 32'hAB);

    // both requesters held continuously
    rst_n = 0;
    model_reset();
    step();
    rst_n = 1;
    a_hold = 1; b_hold = 1;
    ack_q.delete();
    issue(1'b0, 1'b0, 4'h3, 8'h00);
    issue(1'b1, 1'b0, 4'hA, 8'h00);
    for (int n = 0; n < 60 && ack_q.size() < 4; n++) step();
    chk("hold_ack_count", 32'(ack_q.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      chk($sformatf("hold_order_%0d", i), 32'(ack_q[i]), 32'(i % 2));
`else
      chk($sformatf("hold_order_%0d", i), 32'(ack_q[i]), 32'h0);
`endif
    end
    a_hold = 0; b_hold = 0;
    rst_n = 0;
    model_reset();
    a_req = 0; b_req = 0;
    step();
    rst_n = 1;
    step();

    // random traffic on both ports
    rand_mode = 1;
    repeat (600) step();
    rand_mode = 0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
